cpu_debug_host: RTL and testbench

- Host-side initiator for the CPU core's external debug/load port (`cmd`/`addr_in`/`data_in`/`data_out`) and for the core's `reset` input.
- Parses command frames from a byte stream (valid/ready, typically fed by a UART receiver).
- Issues the corresponding I-cache writes, D-cache writes, D-cache reads and register reads, and controls CPU hold/release.
- Returns acknowledgements and read data as a byte stream.
- Sits between the host link and `CPU_top`.

---
 rtl/debug_pkg.sv | 46 ++++
 rtl/cpu_debug_host_if.sv | 30 +++
 rtl/word_serializer.sv | 48 ++++
 rtl/cpu_debug_host.sv | 165 ++++++++++++++++
 tb/tb_cpu_debug_host.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared opcodes, core-port command encodings and FSM states
// for the host-side debug/load initiator.
package debug_pkg;

  localparam logic [7:0] OP_REG_RD  = 8'h00;
  localparam logic [7:0] OP_IMEM_WR = 8'h01;
  localparam logic [7:0] OP_DMEM_RD = 8'h02;
  localparam logic [7:0] OP_DMEM_WR = 8'h03;
  localparam logic [7:0] OP_HOLD    = 8'h10;
  localparam logic [7:0] OP_RUN     = 8'h11;

  localparam logic [1:0] CMD_REG_RD  = 2'b00;
  localparam logic [1:0] CMD_IMEM_WR = 2'b01;
  localparam logic [1:0] CMD_DMEM_RD = 2'b10;
  localparam logic [1:0] CMD_DMEM_WR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_RDWAIT,
    ST_TX,
    ST_RESP
  } state_t;

  // Core command for a frame opcode; non-access opcodes map to idle.
  function automatic logic [1:0] op_cmd(input logic [7:0] op);
    case (op)
      OP_IMEM_WR: return CMD_IMEM_WR;
      OP_DMEM_RD: return CMD_DMEM_RD;
      OP_DMEM_WR: return CMD_DMEM_WR;
      default:    return CMD_REG_RD;
    endcase
  endfunction

  function automatic logic op_is_wr(input logic [7:0] op);
    return (op == OP_IMEM_WR) || (op == OP_DMEM_WR);
  endfunction

  function automatic logic op_has_addr(input logic [7:0] op);
    return (op == OP_REG_RD) || (op == OP_DMEM_RD) ||
           op_is_wr(op);
  endfunction

endpackage

// File: rtl/cpu_debug_host_if.sv
// Host byte link plus core debug/load port bundle.
// slave = debug host block, master = host link / core side.
interface cpu_debug_host_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_reset;
  logic [1:0]  cpu_cmd;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic [31:0] cpu_rdata;
  logic        busy;

  modport slave (
    input  rx_data, rx_valid, tx_ready, cpu_rdata,
    output rx_ready, tx_data, tx_valid,
    output cpu_reset, cpu_cmd, cpu_addr, cpu_data, busy
  );

  modport master (
    output rx_data, rx_valid, tx_ready, cpu_rdata,
    input  rx_ready, tx_data, tx_valid,
    input  cpu_reset, cpu_cmd, cpu_addr, cpu_data, busy
  );

endinterface

// File: rtl/word_serializer.sv
// Emits up to four bytes of a loaded word, LSB first,
// over a valid/ready link; last_i selects how many bytes.
module word_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_i,
  input  logic [31:0] word_i,
  input  logic [1:0]  last_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        done_o
);

  logic [31:0] sh_q;
  logic        valid_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;
  logic        hs;

  assign hs         = valid_q & tx_ready_i;
  assign tx_data_o  = sh_q[7:0];
  assign tx_valid_o = valid_q;
  assign done_o     = hs & (cnt_q == last_q);

  // Load a word, then shift one byte out per accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else if (ld_i) begin
      sh_q    <= word_i;
      valid_q <= 1'b1;
      cnt_q   <= '0;
      last_q  <= last_i;
    end else if (hs) begin
      if (cnt_q == last_q) begin
        valid_q <= 1'b0;
      end else begin
        sh_q  <= {8'h00, sh_q[31:8]};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_debug_host.sv
// Parses host command frames into core debug-port accesses
// and returns ACK/NAK or read data as a byte stream.
module cpu_debug_host
  import debug_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RX_TIMEOUT = 1000000,
  parameter logic [7:0]  ACK        = 8'hA5,
  parameter logic [7:0]  NAK        = 8'h5A
) (
  input logic              clk,
  input logic              reset,
  cpu_debug_host_if.slave  bus
);

  localparam logic [23:0] TMO_LAST = 24'(RX_TIMEOUT - 1);
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT);

  state_t      state_q;
  logic [7:0]  op_q;
  logic [7:0]  resp_q;
  logic [1:0]  cnt_q;
  logic [23:0] tmo_q;
  logic [2:0]  lat_q;
  logic [1:0]  cmd_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic        hold_q;
  logic        ld_q;

  logic        acc;
  logic        ser_done;
  logic [31:0] ser_word;
  logic [1:0]  ser_last;

  assign bus.rx_ready = (state_q == ST_IDLE) ||
                        (state_q == ST_ADDR) ||
                        (state_q == ST_DATA);
  assign bus.busy     = (state_q != ST_IDLE);
  assign acc          = bus.rx_valid & bus.rx_ready;

  assign bus.cpu_reset = hold_q;
  assign bus.cpu_cmd   = cmd_q;
  assign bus.cpu_addr  = addr_q;
  assign bus.cpu_data  = data_q;

  assign ser_word = (state_q == ST_TX) ? rdata_q
                                       : {24'h0, resp_q};
  assign ser_last = (state_q == ST_TX) ? 2'd3 : 2'd0;

  // Frame parser / executor; every core-facing output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
      cmd_q   <= CMD_REG_RD;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      hold_q  <= 1'b1;
      ld_q    <= 1'b0;
    end else begin
      ld_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (acc) begin
            op_q  <= bus.rx_data;
            cnt_q <= '0;
            tmo_q <= '0;
            unique case (1'b1)
              op_has_addr(bus.rx_data): state_q <= ST_ADDR;
              (bus.rx_data == OP_HOLD) ||
              (bus.rx_data == OP_RUN):  state_q <= ST_EXEC;
              default: begin
                resp_q  <= NAK;
                ld_q    <= 1'b1;
                state_q <= ST_RESP;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (acc) begin
            addr_q <= {bus.rx_data, addr_q[31:8]};
            cnt_q  <= cnt_q + 2'd1;
            tmo_q  <= '0;
            if (cnt_q == 2'd3) begin
              if (op_is_wr(op_q)) begin
                state_q <= ST_DATA;
              end else begin
                cmd_q   <= op_cmd(op_q);
                lat_q   <= '0;
                state_q <= ST_RDWAIT;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        ST_DATA: begin
          if (acc) begin
            data_q <= {bus.rx_data, data_q[31:8]};
            cnt_q  <= cnt_q + 2'd1;
            tmo_q  <= '0;
            if (cnt_q == 2'd3) begin
              // Writes only land while the core is held.
              if (hold_q) cmd_q <= op_cmd(op_q);
              state_q <= ST_EXEC;
            end
          end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        ST_EXEC: begin
          cmd_q <= CMD_REG_RD;
          if (op_q == OP_HOLD) hold_q <= 1'b1;
          if (op_q == OP_RUN)  hold_q <= 1'b0;
          // A write that produced no pulse was refused.
          resp_q <= (op_is_wr(op_q) && cmd_q == CMD_REG_RD)
                    ? NAK : ACK;
          ld_q    <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RDWAIT: begin
          if (lat_q == LAT_LAST) begin
            rdata_q <= bus.cpu_rdata;
            cmd_q   <= CMD_REG_RD;
            ld_q    <= 1'b1;
            state_q <= ST_TX;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        ST_TX, ST_RESP: begin
          if (ser_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  word_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .ld_i       (ld_q),
    .word_i     (ser_word),
    .last_i     (ser_last),
    .tx_ready_i (bus.tx_ready),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .done_o     (ser_done)
  );

endmodule

// File: tb/tb_cpu_debug_host.sv
// Directed bench for cpu_debug_host: writes, refusals, reads
// with stall, bad opcode, rx timeout, reset mid-frame.
module tb_cpu_debug_host;
  import debug_pkg::*;

  localparam int unsigned RD_LAT = 1;
  localparam int unsigned RX_TMO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  int n_iwr = 0;
  int n_dwr = 0;
  int n_drd = 0;
  int n_txv = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  cpu_debug_host_if bus();

  cpu_debug_host #(
    .RD_LAT     (RD_LAT),
    .RX_TIMEOUT (RX_TMO),
    .ACK        (8'hA5),
    .NAK        (8'h5A)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Core data_out model.
  always_comb begin
    bus.cpu_rdata = 32'h0;
    if (bus.cpu_cmd == 2'b10 && bus.cpu_addr == 32'h200)
      bus.cpu_rdata = 32'hDEADBEEF;
    else if (bus.cpu_cmd == 2'b00 && bus.cpu_addr == 32'h40)
      bus.cpu_rdata = 32'h12345678;
  end

  // Cycle monitor of core commands and tx activity.
  always @(negedge clk) begin
    if (bus.cpu_cmd == 2'b01) n_iwr <= n_iwr + 1;
    if (bus.cpu_cmd == 2'b11) n_dwr <= n_dwr + 1;
    if (bus.cpu_cmd == 2'b10) n_drd <= n_drd + 1;
    if (bus.cpu_cmd[0]) begin
      wr_addr <= bus.cpu_addr;
      wr_data <= bus.cpu_data;
    end
    if (bus.tx_valid) n_txv <= n_txv + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d",
             checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.rx_ready) begin
      errors++;
      $display("FAIL send_byte %h: rx_ready=0 want 1", b);
    end else begin
      tick();
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    bus.tx_ready = 1'b1;
    while (!bus.tx_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.tx_valid) begin
      errors++;
      $display("FAIL recv_byte: tx_valid=0 want 1");
    end else begin
      b = bus.tx_data;
      tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.cpu_reset !== 1'b1 || bus.cpu_cmd !== 2'b00) begin
      errors++;
      $display("FAIL reset_cpu: cpu_reset=%b cmd=%b want 1 00",
               bus.cpu_reset, bus.cpu_cmd);
    end
    checks++;
    if (bus.cpu_addr !== 32'h0 || bus.cpu_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h want 0 0",
               bus.cpu_addr, bus.cpu_data);
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 ||
        bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_link: txv=%b txd=%h rdy=%b busy=%b want 0 00 1 0",
               bus.tx_valid, bus.tx_data, bus.rx_ready, bus.busy);
    end
  endtask

  task automatic test_imem_write();
    int i0;
    logic [7:0] b;
    i0 = n_iwr;
    send_byte(OP_IMEM_WR);
    send_word(32'h00000100);
    send_word(32'h00000013);
    checks++;
    if (bus.cpu_cmd !== 2'b01 || bus.cpu_addr !== 32'h100 ||
        bus.cpu_data !== 32'h13) begin
      errors++;
      $display("FAIL imem_exec: cmd=%b addr=%h data=%h want 01 100 13",
               bus.cpu_cmd, bus.cpu_addr, bus.cpu_data);
    end
    tick();
    checks++;
    if (bus.cpu_cmd !== 2'b00 || bus.tx_valid !== 1'b0 ||
        bus.cpu_addr !== 32'h100 || bus.cpu_data !== 32'h13) begin
      errors++;
      $display("FAIL imem_post: cmd=%b txv=%b addr=%h data=%h want 00 0 100 13",
               bus.cpu_cmd, bus.tx_valid, bus.cpu_addr, bus.cpu_data);
    end
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL imem_ack_lat: txv=%b txd=%h want 1 a5",
               bus.tx_valid, bus.tx_data);
    end
    recv_byte(b);
    tick();
    checks++;
    if (n_iwr - i0 != 1 || b !== 8'hA5) begin
      errors++;
      $display("FAIL imem_pulse: pulses=%0d ack=%h want 1 a5",
               n_iwr - i0, b);
    end
  endtask

  task automatic test_run_reject();
    int d0;
    logic [7:0] b;
    send_byte(OP_RUN);
    recv_byte(b);
    checks++;
    if (b !== 8'hA5 || bus.cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL run_ack: byte=%h cpu_reset=%b want a5 0",
               b, bus.cpu_reset);
    end
    d0 = n_dwr;
    send_byte(OP_DMEM_WR);
    send_word(32'h00000200);
    send_word(32'h11223344);
    recv_byte(b);
    checks++;
    if (b !== 8'h5A) begin
      errors++;
      $display("FAIL reject_nak: byte=%h want 5a", b);
    end
    checks++;
    if (n_dwr != d0 || bus.cpu_reset !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_state: pulses=%0d cpu_reset=%b busy=%b want 0 0 0",
               n_dwr - d0, bus.cpu_reset, bus.busy);
    end
  endtask

  task automatic test_read_stall();
    int r0;
    logic [7:0] b;
    r0 = n_drd;
    send_byte(OP_DMEM_RD);
    send_word(32'h00000200);
    checks++;
    if (bus.cpu_cmd !== 2'b10 || bus.cpu_addr !== 32'h200) begin
      errors++;
      $display("FAIL rd_cmd: cmd=%b addr=%h want 10 200",
               bus.cpu_cmd, bus.cpu_addr);
    end
    tick();
    checks++;
    if (bus.cpu_cmd !== 2'b10 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: cmd=%b txv=%b want 10 0",
               bus.cpu_cmd, bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.cpu_cmd !== 2'b00 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_end: cmd=%b txv=%b want 00 0",
               bus.cpu_cmd, bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEF) begin
      errors++;
      $display("FAIL rd_lat: txv=%b txd=%h want 1 ef",
               bus.tx_valid, bus.tx_data);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hEF) begin
      errors++;
      $display("FAIL rd_b0: got %h want ef", b);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hBE) begin
      errors++;
      $display("FAIL rd_b1: got %h want be", b);
    end
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hAD) begin
        errors++;
        $display("FAIL rd_stall%0d: txv=%b txd=%h want 1 ad",
                 i, bus.tx_valid, bus.tx_data);
      end
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hAD) begin
      errors++;
      $display("FAIL rd_b2: got %h want ad", b);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hDE || bus.busy !== 1'b0 ||
        n_drd - r0 != int'(RD_LAT) + 1) begin
      errors++;
      $display("FAIL rd_b3: byte=%h busy=%b rdcyc=%0d want de 0 2",
               b, bus.busy, n_drd - r0);
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b;
    send_byte(8'h7F);
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL nak_early: txv=%b want 0", bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL nak_lat: txv=%b txd=%h want 1 5a",
               bus.tx_valid, bus.tx_data);
    end
    send_byte(OP_HOLD);
    checks++;
    if (bus.cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL hold_early: cpu_reset=%b want 0",
               bus.cpu_reset);
    end
    tick();
    checks++;
    if (bus.cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL hold_set: cpu_reset=%b want 1", bus.cpu_reset);
    end
    recv_byte(b);
    checks++;
    if (b !== 8'hA5) begin
      errors++;
      $display("FAIL hold_ack: got %h want a5", b);
    end
  endtask

  task automatic test_timeout();
    int t0;
    logic [7:0] b;
    logic [31:0] w;
    t0 = n_txv;
    send_byte(OP_REG_RD);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (RX_TMO - 1) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: busy=%b want 1", bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b1 ||
        n_txv != t0) begin
      errors++;
      $display("FAIL tmo_idle: busy=%b rdy=%b txcyc=%0d want 0 1 0",
               bus.busy, bus.rx_ready, n_txv - t0);
    end
    send_byte(OP_REG_RD);
    send_word(32'h00000040);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      w[8*i +: 8] = b;
    end
    checks++;
    if (w !== 32'h12345678) begin
      errors++;
      $display("FAIL tmo_next_rd: got %h want 12345678", w);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    w0 = n_iwr;
    send_byte(OP_IMEM_WR);
    send_word(32'h00000500);
    send_byte(8'hEF);
    send_byte(8'hBE);
    bus.rx_data  = 8'hAD;
    bus.rx_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cpu_reset !== 1'b1 || bus.cpu_cmd !== 2'b00 ||
        bus.cpu_addr !== 32'h0 || bus.cpu_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_cpu: rst=%b cmd=%b addr=%h data=%h want 1 00 0 0",
               bus.cpu_reset, bus.cpu_cmd, bus.cpu_addr,
               bus.cpu_data);
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 ||
        bus.busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_link: txv=%b txd=%h busy=%b rdy=%b want 0 00 0 1",
               bus.tx_valid, bus.tx_data, bus.busy, bus.rx_ready);
    end
    tick();
    bus.rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (n_iwr != w0 || bus.busy !== 1'b0 ||
        bus.cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after: pulses=%0d busy=%b rst=%b want 0 0 1",
               n_iwr - w0, bus.busy, bus.cpu_reset);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [7:0] b;
    logic [31:0] w;
    d0 = n_dwr;
    send_byte(OP_DMEM_WR);
    send_word(32'h00000300);
    send_word(32'hCAFEF00D);
    recv_byte(b);
    checks++;
    if (b !== 8'hA5 || n_dwr - d0 != 1) begin
      errors++;
      $display("FAIL b2b_wr: ack=%h pulses=%0d want a5 1",
               b, n_dwr - d0);
    end
    checks++;
    if (wr_addr !== 32'h300 || wr_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_wrbus: addr=%h data=%h want 300 cafef00d",
               wr_addr, wr_data);
    end
    send_byte(OP_DMEM_RD);
    send_word(32'h00000200);
    w = '0;
    for (int i = 0; i < 4; i++) begin
      recv_byte(b);
      w[8*i +: 8] = b;
    end
    checks++;
    if (w !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_rd: got %h want deadbeef", w);
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_imem_write();
    test_run_reject();
    test_read_stall();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
